// File: rtl/jt12_wrq_pkg.sv
// Shared definitions for the jt12 host write queue.
package jt12_wrq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      SETTLE = 2'd2,
      POLL   = 2'd3
   } state_t;

   localparam int unsigned ENTRY_W  = 10;
   localparam int unsigned BUSY_BIT = 7;

   typedef struct packed {
      logic [1:0] addr;
      logic [7:0] data;
   } entry_t;

endpackage

// File: rtl/jt12_wrq_fifo.sv
// Synchronous show-ahead FIFO; a pop on a full FIFO frees a slot for a same-clock push.
module jt12_wrq_fifo #(
   parameter int unsigned DW = 4,
   parameter int unsigned W  = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [DW:0]   level
);

   localparam int unsigned DEPTH    = 1 << DW;
   localparam logic [DW:0] FULL_LVL = (DW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [DW-1:0] wr_ptr;
   logic [DW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty   = (level == '0);
   assign full    = (level == FULL_LVL);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/jt12_wrq.sv
// Host register write queue in front of jt12: buffers writes and replays them
// honouring the strobe width, settle gap and the chip busy flag.
module jt12_wrq
   import jt12_wrq_pkg::*;
#(
   parameter int unsigned DW      = 4,
   parameter int unsigned GAP     = 2,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          host_wr,
   input  logic [1:0]    host_addr,
   input  logic [7:0]    host_din,
   input  logic          clr_err,
   output logic          host_full,
   output logic          host_empty,
   output logic [DW:0]   host_level,
   output logic          overflow,
   output logic          timeout,
   output logic [7:0]    host_dout,
   output logic [7:0]    ym_din,
   output logic [1:0]    ym_addr,
   output logic          ym_cs_n,
   output logic          ym_wr_n,
   input  logic [7:0]    ym_dout
);

   localparam int unsigned CMAX = (GAP > TIMEOUT) ? GAP : TIMEOUT;
   localparam int unsigned CW   = (CMAX < 2) ? 1 : $clog2(CMAX + 1);
   localparam logic [CW-1:0] GAP_C   = CW'(GAP);
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] ONE_C   = CW'(1);

   state_t        state;
   logic [CW-1:0] cnt;
   entry_t        head;
   entry_t        new_entry;
   logic          pop;
   logic          ym_busy;
   logic          ovf_set;
   logic          to_set;

   assign new_entry = '{addr: host_addr, data: host_din};
   assign ym_busy   = ym_dout[BUSY_BIT];
   assign pop       = cen && (state == IDLE) && !host_empty;
   // A same-clock pop makes room, so only a push against a full, non-draining queue is lost.
   assign ovf_set   = host_wr && host_full && !pop;
   assign to_set    = cen && (state == POLL) && ym_busy && (cnt == TO_LAST);
   assign host_dout = {ym_busy | ~host_empty | (state != IDLE), ym_dout[6:0]};

   jt12_wrq_fifo #(
      .DW (DW),
      .W  (ENTRY_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (host_wr),
      .pop   (pop),
      .din   (new_entry),
      .dout  (head),
      .full  (host_full),
      .empty (host_empty),
      .level (host_level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         overflow <= ovf_set | (overflow & ~clr_err);
         timeout  <= to_set  | (timeout  & ~clr_err);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         ym_din  <= '0;
         ym_addr <= '0;
         ym_cs_n <= 1'b1;
         ym_wr_n <= 1'b1;
      end else if (cen) begin
         case (state)
            IDLE: begin
               if (!host_empty) begin
                  ym_addr <= head.addr;
                  ym_din  <= head.data;
                  ym_cs_n <= 1'b0;
                  ym_wr_n <= 1'b0;
                  state   <= STROBE;
               end
            end
            STROBE: begin
               ym_cs_n <= 1'b1;
               ym_wr_n <= 1'b1;
               cnt     <= GAP_C;
               state   <= SETTLE;
            end
            SETTLE: begin
               // The edge that takes cnt to zero is the last settle cycle.
               if (cnt <= ONE_C) begin
                  cnt   <= '0;
                  state <= ym_addr[0] ? POLL : IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            POLL: begin
               if (!ym_busy) begin
                  state <= IDLE;
               end else if (cnt == TO_LAST) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_jt12_wrq.sv
// Directed bench for jt12_wrq with a scoreboard of expected strobed entries.
module tb_jt12_wrq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b0;
   logic       host_wr = 1'b0;
   logic [1:0] host_addr = '0;
   logic [7:0] host_din = '0;
   logic       clr_err = 1'b0;
   logic       host_full;
   logic       host_empty;
   logic [4:0] host_level;
   logic       overflow;
   logic       timeout;
   logic [7:0] host_dout;
   logic [7:0] ym_din;
   logic [1:0] ym_addr;
   logic       ym_cs_n;
   logic       ym_wr_n;
   logic [7:0] ym_dout;

   logic        busy_force = 1'b0;
   bit          model_en = 1'b0;
   int unsigned busy_cnt = 0;
   int unsigned cen_cnt = 0;
   int unsigned strobe_cnt = 0;
   int unsigned strobe_t[$];
   logic [9:0]  exp_q[$];
   logic        prev_cs_n = 1'b1;
   bit          watch = 1'b0;
   bit          hd_low = 1'b0;
   int          n_cmp = 0;
   int          n_err = 0;

   assign ym_dout = {busy_force | (busy_cnt != 0), 7'h15};

   jt12_wrq #(
      .DW      (4),
      .GAP     (2),
      .TIMEOUT (255)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cen        (cen),
      .host_wr    (host_wr),
      .host_addr  (host_addr),
      .host_din   (host_din),
      .clr_err    (clr_err),
      .host_full  (host_full),
      .host_empty (host_empty),
      .host_level (host_level),
      .overflow   (overflow),
      .timeout    (timeout),
      .host_dout  (host_dout),
      .ym_din     (ym_din),
      .ym_addr    (ym_addr),
      .ym_cs_n    (ym_cs_n),
      .ym_wr_n    (ym_wr_n),
      .ym_dout    (ym_dout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (cen) cen_cnt <= cen_cnt + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Strobe monitor, scoreboard and jt12 busy model
   always @(negedge clk) begin
      logic [9:0] e;
      if (!ym_cs_n && prev_cs_n) begin
         strobe_cnt++;
         strobe_t.push_back(cen_cnt);
         check("strobe_wr_n", {31'd0, ym_wr_n}, 32'd0);
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
         check("strobe_entry", {22'd0, ym_addr, ym_din}, {22'd0, e});
         if (model_en && ym_addr[0]) busy_cnt = 30;
      end else if (cen && busy_cnt != 0) begin
         busy_cnt--;
      end
      if (watch && !host_dout[7]) hd_low = 1'b1;
      prev_cs_n = ym_cs_n;
   end

   task automatic push(input logic [1:0] a, input logic [7:0] d, input bit acc);
      host_wr   = 1'b1;
      host_addr = a;
      host_din  = d;
      if (acc) exp_q.push_back({a, d});
      @(negedge clk);
      host_wr = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_strobes(input int unsigned n, input int limit, input string tag);
      for (int i = 0; i < limit && strobe_t.size() < n; i++) @(negedge clk);
      check(tag, strobe_t.size(), n);
   endtask

   task automatic wait_idle(input int limit, input string tag);
      for (int i = 0; i < limit && !(host_empty && !host_dout[7]); i++) @(negedge clk);
      check(tag, {31'd0, host_dout[7]}, 32'd0);
   endtask

   initial begin
      int unsigned t0;
      int unsigned s0;

      // Reset state
      #12;
      check("rst_cs_n", {31'd0, ym_cs_n}, 32'd1);
      check("rst_wr_n", {31'd0, ym_wr_n}, 32'd1);
      check("rst_din", {24'd0, ym_din}, 32'd0);
      check("rst_addr", {30'd0, ym_addr}, 32'd0);
      check("rst_level", {27'd0, host_level}, 32'd0);
      check("rst_empty", {31'd0, host_empty}, 32'd1);
      check("rst_flags", {30'd0, overflow, timeout}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cen = 1'b1;
      cycles(2);

      // 1: address writes never poll, even with busy stuck high
      busy_force = 1'b1;
      t0 = strobe_t.size();
      push(2'd0, 8'h28, 1);
      push(2'd0, 8'h2A, 1);
      check("t1_cs_low", {31'd0, ym_cs_n}, 32'd0);
      check("t1_addr_din", {22'd0, ym_addr, ym_din}, {22'd0, 2'd0, 8'h28});
      @(negedge clk);
      check("t1_strobe_one_cen", {31'd0, ym_cs_n}, 32'd1);
      wait_strobes(t0 + 2, 20, "t1_strobes");
      check("t1_spacing", strobe_t[t0+1] - strobe_t[t0], 32'd4);
      cycles(6);
      busy_force = 1'b0;
      @(negedge clk);
      check("t1_hd_idle", {24'd0, host_dout}, 32'h15);
      check("t1_empty", {31'd0, host_empty}, 32'd1);

      // 2: address/data pair, data write polls the 30-cen busy window
      model_en = 1'b1;
      hd_low = 1'b0;
      t0 = strobe_t.size();
      push(2'd0, 8'h28, 1);
      watch = 1'b1;
      push(2'd1, 8'hF0, 1);
      push(2'd0, 8'h2A, 1);
      wait_strobes(t0 + 3, 100, "t2_strobes");
      watch = 1'b0;
      check("t2_addr_to_data", strobe_t[t0+1] - strobe_t[t0], 32'd4);
      check("t2_data_to_next", strobe_t[t0+2] - strobe_t[t0+1], 32'd32);
      check("t2_busy_flag_held", {31'd0, hd_low}, 32'd0);
      wait_idle(100, "t2_idle");
      model_en = 1'b0;

      // 3: overflow while the FSM sits in POLL
      busy_force = 1'b1;
      push(2'd1, 8'h11, 1);
      cycles(8);
      for (int i = 0; i < 17; i++) push(2'd0, 8'h80 + 8'(i), i < 16);
      check("t3_level", {27'd0, host_level}, 32'd16);
      check("t3_full", {31'd0, host_full}, 32'd1);
      check("t3_overflow", {31'd0, overflow}, 32'd1);
      cen = 1'b0;
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      check("t3_clr_err", {31'd0, overflow}, 32'd0);

      // 4: push and pop in the same clock while full
      busy_force = 1'b0;
      cen = 1'b1;
      @(negedge clk);
      push(2'd0, 8'hEE, 1);
      cen = 1'b0;
      check("t4_level", {27'd0, host_level}, 32'd16);
      check("t4_full", {31'd0, host_full}, 32'd1);
      check("t4_overflow", {31'd0, overflow}, 32'd0);
      cen = 1'b1;
      wait_idle(200, "t4_drain");

      // 5: busy stuck, poll times out after 255 cen and the queue continues
      busy_force = 1'b1;
      t0 = strobe_t.size();
      push(2'd1, 8'h55, 1);
      push(2'd0, 8'h66, 1);
      wait_strobes(t0 + 1, 10, "t5_first");
      cycles(200);
      check("t5_no_early_timeout", {31'd0, timeout}, 32'd0);
      wait_strobes(t0 + 2, 200, "t5_second");
      check("t5_timeout", {31'd0, timeout}, 32'd1);
      check("t5_spacing", strobe_t[t0+1] - strobe_t[t0], 32'd259);
      busy_force = 1'b0;
      wait_idle(50, "t5_idle");

      // 6: reset in the middle of a strobe with work queued
      cen = 1'b0;
      for (int i = 0; i < 17; i++) push(2'd0, 8'hA0 + 8'(i), i < 16);
      check("t6_pre_overflow", {31'd0, overflow}, 32'd1);
      cen = 1'b1;
      @(negedge clk);
      cen = 1'b0;
      check("t6_cs_low", {31'd0, ym_cs_n}, 32'd0);
      check("t6_level", {27'd0, host_level}, 32'd15);
      #2 rst = 1'b1;
      #1;
      check("t6_cs_n", {31'd0, ym_cs_n}, 32'd1);
      check("t6_wr_n", {31'd0, ym_wr_n}, 32'd1);
      check("t6_level0", {27'd0, host_level}, 32'd0);
      check("t6_flags", {30'd0, overflow, timeout}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      cen = 1'b1;
      s0 = strobe_cnt;
      cycles(20);
      check("t6_no_strobes", strobe_cnt, s0);
      check("t6_empty", {31'd0, host_empty}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/jt12_wrq.md
Name: jt12_wrq

Overview:
Host-side register write queue that sits directly upstream of the jt12 FM core and drives its din/addr/cs_n/wr_n bus.
- Buffers CPU (68k/Z80) register writes, then replays them into jt12 one at a time.
- Honours jt12's busy flag (dout[7]) and a minimum inter-write gap, so the host never stalls on YM2612 timing.
- Returns a merged status byte to the host.

Parameters:
DW, 4, log2 of FIFO depth (16 entries of {addr[1:0], data[7:0]})
GAP, 2, cen-qualified cycles after write strobe release before busy is sampled or the next write is allowed
TIMEOUT, 255, maximum cen-qualified cycles spent polling busy before the write is abandoned

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
cen  in  1  clock enable, same as jt12's cen
host_wr  in  1  single-cycle push request
host_addr  in  2  YM register port (0/2 = address, 1/3 = data)
host_din  in  8  write data
clr_err  in  1  clears overflow and timeout
host_full  out  1  FIFO full
host_empty  out  1  FIFO empty
host_level  out  DW+1  FIFO occupancy
overflow  out  1  sticky: a push was dropped
timeout  out  1  sticky: busy poll expired
host_dout  out  8  {ym_dout[7] | ~host_empty | ~idle, ym_dout[6:0]}
ym_din  out  8  to jt12 din
ym_addr  out  2  to jt12 addr
ym_cs_n  out  1  to jt12 cs_n
ym_wr_n  out  1  to jt12 wr_n
ym_dout  in  8  from jt12 dout

Behaviour:
- Reset (async, immediate):
  - FIFO empty, level=0, overflow=0, timeout=0, state=IDLE.
  - ym_cs_n=1, ym_wr_n=1, ym_din=0, ym_addr=0.
  - Reset mid-strobe deasserts cs_n/wr_n in the same instant; the in-flight entry is lost.
- FIFO side (every clk, not gated by cen):
  - Push when host_wr && !full.
  - host_wr && full sets overflow and drops the entry. Exception: a pop in the same clk frees a slot and the push is accepted.
  - Pointers wrap modulo 2^DW. level = count, range 0..2^DW.
  - clr_err clears both sticky flags. A set event in the same clk wins over clr_err.
- FSM (advances only on cen-qualified edges):
  - IDLE: if !empty, pop head, load ym_addr/ym_din, drive ym_cs_n=0 and ym_wr_n=0, go to STROBE.
  - STROBE: drive ym_cs_n=1 and ym_wr_n=1, load cnt=GAP, go to SETTLE. The strobe is low for exactly one cen period.
  - SETTLE: cnt--. When cnt reaches 0, go to POLL if ym_addr[0]=1 (data write), else go to IDLE (address write).
  - POLL: cnt increments each cen.
    - If ym_dout[7]=0, go to IDLE.
    - If cnt reaches TIMEOUT, set timeout and go to IDLE. That entry is considered done; the queue continues.
- Latency:
  - Push to strobe asserted: 1–2 clk when cen=1 and the FSM is idle.
  - Back-to-back address then data writes are spaced by 2+GAP cen cycles.
- ym_addr/ym_din hold their values after the strobe until the next pop.
- host_dout[7] reads 1 whenever any write is pending or in progress, so host drivers polling busy stay correct.
- cen held low: FIFO keeps accepting pushes; the FSM freezes in its current state.

Decomposition:
- Shared package jt12_wrq_pkg holds:
  - state encoding: IDLE, STROBE, SETTLE, POLL (2 bits)
  - entry width constant (10)
  - status bit index BUSY_BIT=7
- One sub-module, jt12_wrq_fifo: synchronous FIFO parameterised by DW and width.
  - Ports: push, pop, din, dout, full, empty, level.
  - Same-clk push+pop is allowed when full or empty, except pop on empty, which is ignored.
- The FSM and counters stay in jt12_wrq.

Test Plan:
1. Single address write, cen=1:
   - Stimulus: push addr=0, din=8'h28.
   - Required: one cen period with cs_n=wr_n=0, ym_addr=0, ym_din=28; FSM returns to IDLE after GAP=2 cen cycles with no POLL; host_dout[7]=0 afterwards.
2. Address/data pair with busy model:
   - Stimulus: push (0,28) then (1,F0); model raises ym_dout[7] for 30 cen after the data write.
   - Required: second strobe follows the first after 4 cen; the FSM stays in POLL until busy drops; host_dout[7]=1 throughout.
3. Overflow:
   - Stimulus: hold the FSM with busy stuck (TIMEOUT large); push 17 entries with DW=4.
   - Required: level=16, full=1, overflow=1; the 17th entry is dropped. clr_err then clears overflow.
4. Full with simultaneous push and pop:
   - Stimulus: level=16, FSM pops in the same clk as host_wr.
   - Required: push accepted, level stays 16, overflow stays 0.
5. Busy timeout:
   - Stimulus: ym_dout[7] tied to 1, TIMEOUT=255.
   - Required: after 255 POLL cen cycles timeout=1, the next queued entry is strobed, and the queue keeps draining.
6. Reset mid-strobe:
   - Stimulus: assert rst while cs_n=0 with 3 entries queued.
   - Required: cs_n/wr_n=1 asynchronously, level=0, flags=0, and no further strobes after rst is released.
